// File: rtl/alu_response_checker.sv
// alu_response_checker: run-time checker placed beside an n-bit ALU.
// Accepts one observed ALU transaction per beat, recomputes the expected
// result/zero flag, compares, and keeps saturating pass/fail statistics plus
// a capture of the first failing transaction of each session.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, num_checks          session start pulse and beat count (sampled on start)
//   in_valid / in_ready        observed-transaction handshake (in_ready is combinational)
//   operand1, operand2,
//   control, result, zero      observed ALU transaction
//   done, pass                 session complete / no mismatches seen
//   chk_count, err_count       transactions compared / mismatching
//   fail_valid, fail_*         first failing transaction of the session
module alu_response_checker #(
  parameter int unsigned n     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_checks,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [n-1:0]     operand1,
  input  logic [n-1:0]     operand2,
  input  logic [2:0]       control,
  input  logic [n-1:0]     result,
  input  logic             zero,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       fail_control,
  output logic [n-1:0]     fail_operand1,
  output logic [n-1:0]     fail_operand2,
  output logic [n-1:0]     fail_result
);

  localparam int unsigned SH_W = $clog2(n);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_acc;
  logic             w_accept;
  logic             w_start_ok;
  logic [n-1:0]     w_exp;
  logic [CNT_W-1:0] w_chk_next;
  logic [CNT_W-1:0] w_err_next;

  // Stage 1: accepted beat plus expected values
  logic             r_s1_valid;
  logic [2:0]       r_s1_ctrl;
  logic [n-1:0]     r_s1_op1;
  logic [n-1:0]     r_s1_op2;
  logic [n-1:0]     r_s1_res;
  logic             r_s1_zero;
  logic [n-1:0]     r_s1_exp;

  // Stage 2: compare outcome, consumed by the counters
  logic             r_s2_valid;
  logic             r_s2_mis;
  logic [2:0]       r_s2_ctrl;
  logic [n-1:0]     r_s2_op1;
  logic [n-1:0]     r_s2_op2;
  logic [n-1:0]     r_s2_res;

  assign in_ready   = (r_state == S_RUN) && (r_acc < r_num);
  assign w_accept   = in_valid && in_ready;
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Golden ALU model; carries dropped by the n-bit result width
  always_comb begin
    w_exp = '0;
    case (control)
      3'b000:  w_exp = operand1 + operand2;
      3'b001:  w_exp = operand1 - operand2;
      3'b010:  w_exp = operand1 & operand2;
      3'b011:  w_exp = operand1 | operand2;
      3'b100:  w_exp = operand1 ^ operand2;
      3'b101:  w_exp = ~(operand1 | operand2);
      3'b110:  w_exp = operand1 << operand2[SH_W-1:0];
      default: w_exp = n'(operand1 < operand2);
    endcase
  end

  // Saturating counter next values, driven by the stage-2 outcome
  always_comb begin
    w_chk_next = chk_count;
    w_err_next = err_count;
    if (r_s2_valid && (chk_count != '1)) w_chk_next = chk_count + CNT_W'(1);
    if (r_s2_valid && r_s2_mis && (err_count != '1)) w_err_next = err_count + CNT_W'(1);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state; DRAIN completes once stage 1 is empty, since stage 2
  // retires into the counters on that same edge
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_acc >= r_num) w_next = S_DRAIN;
      S_DRAIN: if (!r_s1_valid) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  // Two-stage check pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_ctrl  <= '0;
      r_s1_op1   <= '0;
      r_s1_op2   <= '0;
      r_s1_res   <= '0;
      r_s1_zero  <= 1'b0;
      r_s1_exp   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_mis   <= 1'b0;
      r_s2_ctrl  <= '0;
      r_s2_op1   <= '0;
      r_s2_op2   <= '0;
      r_s2_res   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_ctrl <= control;
        r_s1_op1  <= operand1;
        r_s1_op2  <= operand2;
        r_s1_res  <= result;
        r_s1_zero <= zero;
        r_s1_exp  <= w_exp;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mis  <= (r_s1_res != r_s1_exp) || (r_s1_zero != (r_s1_exp == '0));
        r_s2_ctrl <= r_s1_ctrl;
        r_s2_op1  <= r_s1_op1;
        r_s2_op2  <= r_s1_op2;
        r_s2_res  <= r_s1_res;
      end
    end
  end

  // Session bookkeeping: counters, first-failure capture, done/pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num         <= '0;
      r_acc         <= '0;
      chk_count     <= '0;
      err_count     <= '0;
      fail_valid    <= 1'b0;
      fail_control  <= '0;
      fail_operand1 <= '0;
      fail_operand2 <= '0;
      fail_result   <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else if (w_start_ok) begin
      r_num         <= num_checks;
      r_acc         <= '0;
      chk_count     <= '0;
      err_count     <= '0;
      fail_valid    <= 1'b0;
      fail_control  <= '0;
      fail_operand1 <= '0;
      fail_operand2 <= '0;
      fail_result   <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      if (w_accept) r_acc <= r_acc + CNT_W'(1);
      chk_count <= w_chk_next;
      err_count <= w_err_next;
      if (r_s2_valid && r_s2_mis && !fail_valid) begin
        fail_valid    <= 1'b1;
        fail_control  <= r_s2_ctrl;
        fail_operand1 <= r_s2_op1;
        fail_operand2 <= r_s2_op2;
        fail_result   <= r_s2_res;
      end
      if ((r_state == S_DRAIN) && (w_next == S_DONE)) begin
        done <= 1'b1;
        pass <= (w_err_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_response_checker.sv
module tb_alu_response_checker;

  localparam int unsigned N  = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned SH = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_checks = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  operand1 = '0;
  logic [N-1:0]  operand2 = '0;
  logic [2:0]    control = '0;
  logic [N-1:0]  result = '0;
  logic          zero = 1'b0;
  logic          done;
  logic          pass;
  logic [CW-1:0] chk_count;
  logic [CW-1:0] err_count;
  logic          fail_valid;
  logic [2:0]    fail_control;
  logic [N-1:0]  fail_operand1;
  logic [N-1:0]  fail_operand2;
  logic [N-1:0]  fail_result;

  alu_response_checker #(.n(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_checks(num_checks),
    .in_valid(in_valid), .in_ready(in_ready),
    .operand1(operand1), .operand2(operand2), .control(control),
    .result(result), .zero(zero),
    .done(done), .pass(pass), .chk_count(chk_count), .err_count(err_count),
    .fail_valid(fail_valid), .fail_control(fail_control),
    .fail_operand1(fail_operand1), .fail_operand2(fail_operand2),
    .fail_result(fail_result)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct { bit mis; int stamp; } sb_t;
  sb_t sb[$];

  // Reference-model session state
  int           exp_chk, exp_err;
  logic [CW-1:0] mon_prev = '0;
  bit           m_run = 1'b0;
  int           m_acc, m_num, m_err, last_acc, start_cyc;
  bit           m_fv;
  logic [2:0]   m_fc;
  logic [N-1:0] m_fa, m_fb, m_fr;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ALU reference: arithmetic modulo 2^N
  function automatic logic [N-1:0] model_res(input logic [2:0] c, input logic [N-1:0] a, input logic [N-1:0] b);
    longint unsigned la, lb, m;
    la = 64'(a);
    lb = 64'(b);
    m  = 64'(1) << N;
    case (c)
      3'd0:    return N'((la + lb) % m);
      3'd1:    return N'((la + m - lb) % m);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~(a | b);
      3'd6:    return N'((la * (64'(1) << 64'(b[SH-1:0]))) % m);
      default: return (la < lb) ? N'(1) : N'(0);
    endcase
  endfunction

  // Monitor: every counter advance retires one scoreboard entry
  always @(negedge clk) begin
    if (rst_n && (chk_count !== mon_prev)) begin
      sb_t e;
      mon_prev = chk_count;
      check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        exp_chk++;
        if (e.mis) exp_err++;
        check("latency", 64'(cyc), 64'(e.stamp + 2));
        check("chk_count", 64'(chk_count), 64'(exp_chk));
        check("err_count", 64'(err_count), 64'(exp_err));
      end
    end
  end

  task automatic drive_beat(input bit v, input logic [2:0] c, input logic [N-1:0] a,
                            input logic [N-1:0] b, input logic [N-1:0] r, input bit z);
    bit rdy, mis;
    logic [N-1:0] e;
    in_valid = v; control = c; operand1 = a; operand2 = b; result = r; zero = z;
    rdy = m_run && (m_acc < m_num);
    #1;
    check("in_ready", 64'(in_ready), 64'(rdy));
    @(posedge clk); #1;
    if (v && rdy) begin
      e   = model_res(c, a, b);
      mis = (r !== e) || (z !== (e == '0));
      sb.push_back('{mis: mis, stamp: cyc});
      m_acc++;
      last_acc = cyc;
      if (mis) begin
        m_err++;
        if (!m_fv) begin
          m_fv = 1'b1; m_fc = c; m_fa = a; m_fb = b; m_fr = r;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drive_good(input bit v, input logic [2:0] c, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] e;
    e = model_res(c, a, b);
    drive_beat(v, c, a, b, e, e == '0);
  endtask

  // Start pulse with a simultaneous beat that must not be accepted
  task automatic do_start(input int num);
    start = 1'b1; num_checks = CW'(num);
    in_valid = 1'b1; control = 3'($urandom); operand1 = $urandom; operand2 = $urandom;
    result = '0; zero = 1'b0;
    #1;
    check("ready_at_start", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    m_run = 1'b1; m_acc = 0; m_num = num; m_err = 0; m_fv = 1'b0;
    exp_chk = 0; exp_err = 0; mon_prev = '0; sb.delete();
    start_cyc = cyc;
    check("cleared_chk", 64'(chk_count), 64'(0));
    check("cleared_done", 64'(done), 64'(0));
    check("cleared_fail_valid", 64'(fail_valid), 64'(0));
  endtask

  task automatic finish_session();
    int lim, want;
    want = (m_acc == 0) ? start_cyc + 2 : last_acc + 2;
    in_valid = 1'b0;
    lim = 0;
    while (!done && lim < 40) begin
      @(posedge clk); #1;
      lim++;
    end
    check("done", 64'(done), 64'(1));
    check("done_cycle", 64'(cyc), 64'(want));
    check("pass", 64'(pass), 64'(m_err == 0));
    check("chk_final", 64'(chk_count), 64'(m_acc));
    check("err_final", 64'(err_count), 64'(m_err));
    check("fail_valid", 64'(fail_valid), 64'(m_fv));
    if (m_fv) begin
      check("fail_control", 64'(fail_control), 64'(m_fc));
      check("fail_operand1", 64'(fail_operand1), 64'(m_fa));
      check("fail_operand2", 64'(fail_operand2), 64'(m_fb));
      check("fail_result", 64'(fail_result), 64'(m_fr));
    end
    check("ready_in_done", 64'(in_ready), 64'(0));
    @(negedge clk); #1;
    check("sb_drained", 64'(sb.size()), 64'(0));
    m_run = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_pass"}, 64'(pass), 64'(0));
    check({tag, "_chk"}, 64'(chk_count), 64'(0));
    check({tag, "_err"}, 64'(err_count), 64'(0));
    check({tag, "_fail_valid"}, 64'(fail_valid), 64'(0));
    check({tag, "_fail_result"}, 64'(fail_result), 64'(0));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] a, b, e, r;
    logic [2:0] c;
    bit z, v;
    int num;

    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Correct ALU, all opcodes back-to-back
    do_start(8);
    for (int i = 0; i < 8; i++) drive_good(1'b1, 3'(i), 32'd15, 32'd12);
    finish_session();

    // Wrong result on AND
    do_start(8);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) drive_beat(1'b1, 3'd2, 32'd15, 32'd12, 32'd13, 1'b0);
      else        drive_good(1'b1, 3'(i), 32'd15, 32'd12);
    end
    finish_session();

    // Correct result but wrong zero flag on ADD
    do_start(8);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drive_beat(1'b1, 3'd0, 32'd15, 32'd12, 32'd27, 1'b1);
      else        drive_good(1'b1, 3'(i), 32'd15, 32'd12);
    end
    finish_session();

    // Three checks, five offered beats with gaps, stray start mid-run
    do_start(3);
    drive_good(1'b1, 3'd0, 32'd1, 32'd2);
    drive_good(1'b0, 3'd0, 32'd0, 32'd0);
    start = 1'b1; num_checks = CW'(7);
    drive_good(1'b1, 3'd4, 32'hA5A5, 32'hA5A5);
    start = 1'b0;
    drive_good(1'b0, 3'd0, 32'd0, 32'd0);
    drive_good(1'b1, 3'd7, 32'd3, 32'd9);
    drive_good(1'b1, 3'd1, 32'd3, 32'd9);
    drive_good(1'b1, 3'd6, 32'd1, 32'd31);
    finish_session();

    // Empty session, then immediate restart
    do_start(0);
    finish_session();
    do_start(2);
    drive_good(1'b1, 3'd5, 32'hFFFF0000, 32'h0000FFFF);
    drive_good(1'b1, 3'd3, 32'd0, 32'd0);
    finish_session();

    // Asynchronous reset mid-run
    do_start(4);
    drive_good(1'b1, 3'd0, 32'd1, 32'd2);
    drive_beat(1'b1, 3'd1, 32'd5, 32'd3, 32'd7, 1'b0);
    drive_good(1'b0, 3'd0, 32'd0, 32'd0);
    drive_good(1'b0, 3'd0, 32'd0, 32'd0);
    #1 rst_n = 1'b0;
    sb.delete(); mon_prev = '0; m_run = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(1);
    drive_good(1'b1, 3'd2, 32'hF0F0, 32'hFF00);
    finish_session();

    // Randomized sessions
    for (int s = 0; s < 25; s++) begin
      num = int'($urandom_range(1, 10));
      do_start(num);
      while (m_acc < num) begin
        v = ($urandom_range(0, 3) != 0);
        c = 3'($urandom);
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        e = model_res(c, a, b);
        r = e;
        z = (e == '0);
        case ($urandom_range(0, 7))
          0: r = e ^ (N'(1) << $urandom_range(0, N - 1));
          1: z = ~z;
          default: ;
        endcase
        drive_beat(v, c, a, b, r, z);
      end
      if ($urandom_range(0, 1) == 1) drive_good(1'b1, 3'd0, 32'd4, 32'd4);
      finish_session();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
